// File: rtl/mips16_pkg.sv
// Shared encodings for the 16-bit MIPS multicycle control path:
// FSM states, opcodes, ALU op classes and datapath mux selects.
package mips16_pkg;

   typedef enum logic [3:0] {
      S_FETCH  = 4'b0000,
      S_DECODE = 4'b0001,
      S_MEMADR = 4'b0010,
      S_MEMRD  = 4'b0011,
      S_MEMWB  = 4'b0100,
      S_MEMWR  = 4'b0101,
      S_EXEC   = 4'b0110,
      S_RWB    = 4'b0111,
      S_BRANCH = 4'b1000,
      S_JUMP   = 4'b1001
   } state_t;

   localparam logic [3:0] OP_LOAD   = 4'b1000;
   localparam logic [3:0] OP_STORE  = 4'b1001;
   localparam logic [3:0] OP_BRANCH = 4'b1010;
   localparam logic [3:0] OP_JUMP   = 4'b1011;

   localparam logic [1:0] OPALU_ADD = 2'b00;
   localparam logic [1:0] OPALU_BR  = 2'b01;
   localparam logic [1:0] OPALU_R   = 2'b10;

   localparam logic [1:0] SRCB_REG  = 2'b00;
   localparam logic [1:0] SRCB_ONE  = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;
   localparam logic [1:0] SRCB_BOFF = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // Opcodes 1100-1111 are undefined.
   function automatic logic is_illegal(input logic [3:0] op);
      return (op[3:2] == 2'b11);
   endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational state-to-controls map of the multicycle control FSM.
// Only the FETCH-state IR/PC writes depend on anything besides the state.
module control_decode
   import mips16_pkg::*;
(
   input  logic [3:0] state,
   input  logic       mem_ready,
   output logic [1:0] op_alu,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       ior_d,
   output logic       mem_read,
   output logic       mem_write,
   output logic       mem_to_reg,
   output logic       ir_write,
   output logic       reg_write,
   output logic       reg_dst,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] pc_source
);

   // Per-state control decode; unused encodings leave everything at 0.
   always_comb begin
      op_alu        = OPALU_ADD;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      ior_d         = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      mem_to_reg    = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      reg_dst       = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = SRCB_REG;
      pc_source     = PCSRC_ALU;
      case (state)
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = SRCB_ONE;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
         end
         S_DECODE: alu_src_b = SRCB_BOFF;
         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
         end
         S_MEMRD: begin
            mem_read = 1'b1;
            ior_d    = 1'b1;
         end
         S_MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         S_MEMWR: begin
            mem_write = 1'b1;
            ior_d     = 1'b1;
         end
         S_EXEC: begin
            alu_src_a = 1'b1;
            op_alu    = OPALU_R;
         end
         S_RWB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a     = 1'b1;
            op_alu        = OPALU_BR;
            pc_write_cond = 1'b1;
            pc_source     = PCSRC_ALUOUT;
         end
         S_JUMP: begin
            pc_write  = 1'b1;
            pc_source = PCSRC_JUMP;
         end
         default: op_alu = OPALU_ADD;
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// Multicycle main control FSM: state register, next-state sequencing,
// retired-instruction counter and reset gating of the datapath enables.
module control_unit
   import mips16_pkg::*;
(
   input  logic        clock,
   input  logic        reset_n,
   input  logic [3:0]  Opcode,
   input  logic        mem_ready,
   output logic [3:0]  state,
   output logic [1:0]  OpAlu,
   output logic        PCWrite,
   output logic        PCWriteCond,
   output logic        IorD,
   output logic        MemRead,
   output logic        MemWrite,
   output logic        MemtoReg,
   output logic        IRWrite,
   output logic        RegWrite,
   output logic        RegDst,
   output logic        ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic [1:0]  PCSource,
   output logic        illegal_op,
   output logic [15:0] instr_count
);

   state_t      state_r;
   state_t      next_s;
   logic        retire_s;
   logic [15:0] instr_count_r;

   logic pc_write_s, pc_write_cond_s, mem_read_s, mem_write_s;
   logic ir_write_s, reg_write_s;

   // State register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= S_FETCH;
      end else begin
         state_r <= next_s;
      end
   end

   // Next-state sequencing and detection of instruction retirement.
   always_comb begin
      next_s   = S_FETCH;
      retire_s = 1'b0;
      case (state_r)
         S_FETCH:  next_s = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            if (!Opcode[3]) begin
               next_s = S_EXEC;
            end else begin
               case (Opcode)
                  OP_LOAD, OP_STORE: next_s = S_MEMADR;
                  OP_BRANCH:         next_s = S_BRANCH;
                  OP_JUMP:           next_s = S_JUMP;
                  default:           next_s = S_FETCH;
               endcase
            end
         end
         S_MEMADR: next_s = (Opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
         S_MEMRD:  next_s = mem_ready ? S_MEMWB : S_MEMRD;
         S_MEMWR: begin
            next_s   = mem_ready ? S_FETCH : S_MEMWR;
            retire_s = mem_ready;
         end
         S_EXEC:   next_s = S_RWB;
         S_MEMWB, S_RWB, S_BRANCH, S_JUMP: begin
            next_s   = S_FETCH;
            retire_s = 1'b1;
         end
         default:  next_s = S_FETCH;
      endcase
   end

   // Retired-instruction counter, wraps naturally at 16 bits.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         instr_count_r <= 16'd0;
      end else if (retire_s) begin
         instr_count_r <= instr_count_r + 16'd1;
      end else begin
         instr_count_r <= instr_count_r;
      end
   end

   control_decode u_decode (
      .state         (state_r),
      .mem_ready     (mem_ready),
      .op_alu        (OpAlu),
      .pc_write      (pc_write_s),
      .pc_write_cond (pc_write_cond_s),
      .ior_d         (IorD),
      .mem_read      (mem_read_s),
      .mem_write     (mem_write_s),
      .mem_to_reg    (MemtoReg),
      .ir_write      (ir_write_s),
      .reg_write     (reg_write_s),
      .reg_dst       (RegDst),
      .alu_src_a     (ALUSrcA),
      .alu_src_b     (ALUSrcB),
      .pc_source     (PCSource)
   );

   // Enables are gated directly by reset_n so nothing writes while held in reset.
   assign PCWrite     = reset_n & pc_write_s;
   assign PCWriteCond = reset_n & pc_write_cond_s;
   assign MemRead     = reset_n & mem_read_s;
   assign MemWrite    = reset_n & mem_write_s;
   assign IRWrite     = reset_n & ir_write_s;
   assign RegWrite    = reset_n & reg_write_s;
   assign illegal_op  = reset_n & (state_r == S_DECODE) & is_illegal(Opcode);

   assign state       = state_r;
   assign instr_count = instr_count_r;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: per-cycle expected state, controls and
// retired count are queued from a spec-level model and compared as the FSM runs.
module tb_control_unit;

   logic        clock;
   logic        reset_n;
   logic [3:0]  Opcode;
   logic        mem_ready;
   logic [3:0]  state;
   logic [1:0]  OpAlu;
   logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
   logic        IRWrite, RegWrite, RegDst, ALUSrcA;
   logic [1:0]  ALUSrcB;
   logic [1:0]  PCSource;
   logic        illegal_op;
   logic [15:0] instr_count;

   typedef struct {
      logic [3:0]  op;
      logic        mr;
      logic [3:0]  st;
      logic [16:0] ctrl;
      logic [15:0] cnt;
   } exp_t;

   exp_t        sb[$];
   logic [15:0] exp_count;
   int          checks;
   int          failures;

   control_unit dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .Opcode      (Opcode),
      .mem_ready   (mem_ready),
      .state       (state),
      .OpAlu       (OpAlu),
      .PCWrite     (PCWrite),
      .PCWriteCond (PCWriteCond),
      .IorD        (IorD),
      .MemRead     (MemRead),
      .MemWrite    (MemWrite),
      .MemtoReg    (MemtoReg),
      .IRWrite     (IRWrite),
      .RegWrite    (RegWrite),
      .RegDst      (RegDst),
      .ALUSrcA     (ALUSrcA),
      .ALUSrcB     (ALUSrcB),
      .PCSource    (PCSource),
      .illegal_op  (illegal_op),
      .instr_count (instr_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   function automatic logic [16:0] act_ctrl();
      return {OpAlu, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
              IRWrite, RegWrite, RegDst, ALUSrcA, ALUSrcB, PCSource, illegal_op};
   endfunction

   // Expected controls straight from the per-state table.
   function automatic logic [16:0] exp_ctrl(input logic [3:0] st, input logic mr,
                                            input logic [3:0] op);
      logic [1:0] opalu, srcb, pcsrc;
      logic pcw, pcwc, iord, mrd, mwr, m2r, irw, rw, rd, srca, ill;
      opalu = 2'b00; srcb = 2'b00; pcsrc = 2'b00;
      pcw = 1'b0; pcwc = 1'b0; iord = 1'b0; mrd = 1'b0; mwr = 1'b0; m2r = 1'b0;
      irw = 1'b0; rw = 1'b0; rd = 1'b0; srca = 1'b0; ill = 1'b0;
      case (st)
         4'b0000: begin mrd = 1'b1; srcb = 2'b01; irw = mr; pcw = mr; end
         4'b0001: begin srcb = 2'b11; ill = (op[3:2] == 2'b11); end
         4'b0010: begin srca = 1'b1; srcb = 2'b10; end
         4'b0011: begin mrd = 1'b1; iord = 1'b1; end
         4'b0100: begin rw = 1'b1; m2r = 1'b1; end
         4'b0101: begin mwr = 1'b1; iord = 1'b1; end
         4'b0110: begin srca = 1'b1; opalu = 2'b10; end
         4'b0111: begin rw = 1'b1; rd = 1'b1; end
         4'b1000: begin srca = 1'b1; opalu = 2'b01; pcwc = 1'b1; pcsrc = 2'b01; end
         4'b1001: begin pcw = 1'b1; pcsrc = 2'b10; end
         default: opalu = 2'b00;
      endcase
      return {opalu, pcw, pcwc, iord, mrd, mwr, m2r, irw, rw, rd, srca, srcb, pcsrc, ill};
   endfunction

   task automatic push(input logic [3:0] st, input logic mr, input logic [3:0] op);
      exp_t e;
      e.op = op; e.mr = mr; e.st = st;
      e.ctrl = exp_ctrl(st, mr, op);
      e.cnt = exp_count;
      sb.push_back(e);
   endtask

   // Queue the full cycle sequence of one instruction; mem_ready is random where ignored.
   task automatic push_instr(input logic [3:0] op, input int fstall, input int mstall);
      repeat (fstall) push(4'b0000, 1'b0, op);
      push(4'b0000, 1'b1, op);
      push(4'b0001, 1'($urandom_range(0, 1)), op);
      if (op[3:2] == 2'b11) return;
      if (!op[3]) begin
         push(4'b0110, 1'($urandom_range(0, 1)), op);
         push(4'b0111, 1'($urandom_range(0, 1)), op);
      end else if (op == 4'b1000) begin
         push(4'b0010, 1'($urandom_range(0, 1)), op);
         repeat (mstall) push(4'b0011, 1'b0, op);
         push(4'b0011, 1'b1, op);
         push(4'b0100, 1'($urandom_range(0, 1)), op);
      end else if (op == 4'b1001) begin
         push(4'b0010, 1'($urandom_range(0, 1)), op);
         repeat (mstall) push(4'b0101, 1'b0, op);
         push(4'b0101, 1'b1, op);
      end else if (op == 4'b1010) begin
         push(4'b1000, 1'($urandom_range(0, 1)), op);
      end else begin
         push(4'b1001, 1'($urandom_range(0, 1)), op);
      end
      exp_count = exp_count + 16'd1;
   endtask

   // Drive each queued cycle from a falling edge and compare mid-cycle.
   task automatic drain();
      exp_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         Opcode = e.op;
         mem_ready = e.mr;
         #2;
         checks++;
         if (state !== e.st) begin
            failures++;
            $display("FAIL state op=%b got=%b exp=%b", e.op, state, e.st);
         end
         checks++;
         if (act_ctrl() !== e.ctrl) begin
            failures++;
            $display("FAIL ctrl st=%b op=%b got=%b exp=%b", e.st, e.op, act_ctrl(), e.ctrl);
         end
         checks++;
         if (instr_count !== e.cnt) begin
            failures++;
            $display("FAIL instr_count st=%b got=%h exp=%h", e.st, instr_count, e.cnt);
         end
         @(negedge clock);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0; Opcode = 4'b0000; mem_ready = 1'b1;
      #1;
      repeat (2) @(negedge clock);
      #1;
      checks++;
      if (state !== 4'b0000) begin
         failures++; $display("FAIL reset_state got=%b exp=0000", state);
      end
      checks++;
      if (instr_count !== 16'h0000) begin
         failures++; $display("FAIL reset_count got=%h exp=0000", instr_count);
      end
      checks++;
      if ({PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite, illegal_op} !== 7'b0) begin
         failures++;
         $display("FAIL reset_enables got=%b exp=0000000",
                  {PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite, illegal_op});
      end
      checks++;
      if ({ALUSrcB, PCSource, OpAlu, IorD, ALUSrcA} !== 8'b01000000) begin
         failures++;
         $display("FAIL reset_selects got=%b exp=01000000", {ALUSrcB, PCSource, OpAlu, IorD, ALUSrcA});
      end
      @(negedge clock);
      reset_n = 1'b1;
      exp_count = 16'h0000;
   endtask

   task automatic test_rtype();
      push_instr(4'b0010, 0, 0);
      drain();
   endtask

   task automatic test_load_stall();
      push_instr(4'b1000, 0, 3);
      drain();
   endtask

   task automatic test_store();
      push_instr(4'b1001, 0, 0);
      drain();
   endtask

   task automatic test_branch_jump();
      push_instr(4'b1010, 0, 0);
      push_instr(4'b1011, 0, 0);
      drain();
   endtask

   task automatic test_illegal();
      push_instr(4'b1110, 0, 0);
      push_instr(4'b1100, 1, 0);
      drain();
   endtask

   task automatic test_fetch_stall();
      push_instr(4'b0111, 2, 0);
      push_instr(4'b1001, 1, 2);
      drain();
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 30; i++) begin
         push_instr(4'($urandom_range(0, 15)), $urandom_range(0, 2), $urandom_range(0, 2));
      end
      push(4'b0000, 1'b0, 4'b0000);
      drain();
   endtask

   task automatic test_reset_mid();
      push(4'b0000, 1'b1, 4'b1001);
      push(4'b0001, 1'b0, 4'b1001);
      push(4'b0010, 1'b0, 4'b1001);
      push(4'b0101, 1'b0, 4'b1001);
      drain();
      mem_ready = 1'b0;
      #2;
      checks++;
      if (MemWrite !== 1'b1) begin
         failures++; $display("FAIL midreset_pre_memwrite got=%b exp=1", MemWrite);
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if (MemWrite !== 1'b0) begin
         failures++; $display("FAIL midreset_memwrite got=%b exp=0", MemWrite);
      end
      checks++;
      if (state !== 4'b0000) begin
         failures++; $display("FAIL midreset_state got=%b exp=0000", state);
      end
      checks++;
      if (instr_count !== 16'h0000) begin
         failures++; $display("FAIL midreset_count got=%h exp=0000", instr_count);
      end
      exp_count = 16'h0000;
      @(negedge clock);
      reset_n = 1'b1;
      push_instr(4'b0001, 0, 0);
      drain();
   endtask

   task automatic test_wrap();
      force dut.instr_count_r = 16'hFFFF;
      #1;
      release dut.instr_count_r;
      exp_count = 16'hFFFF;
      push_instr(4'b1011, 0, 0);
      push(4'b0000, 1'b0, 4'b0000);
      drain();
   endtask

   initial begin
      checks = 0;
      failures = 0;
      exp_count = 16'h0000;
      test_reset();
      test_rtype();
      test_load_stall();
      test_store();
      test_branch_jump();
      test_illegal();
      test_fetch_stall();
      test_back_to_back();
      test_reset_mid();
      test_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/control_unit.md
# control_unit

Multicycle main control FSM of the 16-bit MIPS datapath. It sequences every instruction through fetch, decode, execute, memory and writeback steps, and drives all datapath enables and mux selects. It also produces the `state` and `OpAlu` values consumed directly downstream by `AluControl`. Memory steps stall on a ready handshake, and the block counts retired instructions.

## Interface
- none: no parameters. All encodings are fixed in `mips16_pkg`.

- `clock`  in  1  system clock; state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `Opcode`  in  4  instruction opcode from the IR; valid from DECODE onward.
- `mem_ready`  in  1  memory completed the current access this cycle.
- `state`  out  4  current FSM state, feeds `AluControl`.
- `OpAlu`  out  2  ALU op class: 00 add, 01 branch compare, 10 R-type.
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `MemtoReg`, `IRWrite`, `RegWrite`, `RegDst`, `ALUSrcA`  out  1 each  datapath controls.
- `ALUSrcB`  out  2  ALU B select: 00 reg, 01 const 1, 10 sign-ext imm, 11 branch offset.
- `PCSource`  out  2  PC mux select: 00 ALU, 01 ALUOut, 10 jump target.
- `illegal_op`  out  1  one-cycle pulse on an undefined opcode.
- `instr_count`  out  16  retired-instruction counter; wraps at 0xFFFF→0x0000.

## Operation
- Opcode classes:
  - 0000–0111: R-type.
  - 1000: load.
  - 1001: store.
  - 1010: branch.
  - 1011: jump.
  - 1100–1111: illegal.
- FETCH 0000: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, OpAlu=00, PCSource=00.
  - IRWrite=PCWrite=mem_ready.
  - Stay in FETCH until mem_ready=1, then go to DECODE.
- DECODE 0001: ALUSrcA=0, ALUSrcB=11, OpAlu=00. Next state:
  - load/store → MEMADR.
  - R-type → EXEC.
  - branch → BRANCH.
  - jump → JUMP.
  - illegal → FETCH, with illegal_op=1 this cycle.
- MEMADR 0010: ALUSrcA=1, ALUSrcB=10, OpAlu=00. Next: load → MEMRD, store → MEMWR.
- MEMRD 0011: MemRead=1, IorD=1. Hold until mem_ready, then go to MEMWB.
- MEMWB 0100: RegWrite=1, MemtoReg=1, RegDst=0. Next: FETCH.
- MEMWR 0101: MemWrite=1, IorD=1. Hold until mem_ready, then go to FETCH.
- EXEC 0110: ALUSrcA=1, ALUSrcB=00, OpAlu=10. Next: RWB.
- RWB 0111: RegWrite=1, RegDst=1, MemtoReg=0. Next: FETCH.
- BRANCH 1000: ALUSrcA=1, ALUSrcB=00, OpAlu=01, PCWriteCond=1, PCSource=01. Next: FETCH.
- JUMP 1001: PCWrite=1, PCSource=10. Next: FETCH.
- Any signal not listed for a state is 0.
- Unused encodings 1010–1111 recover to FETCH on the next edge, with all outputs 0.
- instr_count increments by 1 on each transition into FETCH from MEMWB, MEMWR, RWB, BRANCH or JUMP.
  - Illegal opcodes do not count.
  - FETCH self-loops do not count.

## Timing
- All outputs are Moore decodes of the state register, except IRWrite/PCWrite in FETCH, which are gated by mem_ready.
- Outputs are stable from shortly after the rising edge. `AluControl` samples on the falling edge, so it sees settled `state`/`OpAlu` half a cycle later.
- Instruction latency with mem_ready tied high:
  - load 5 cycles.
  - store, R-type 4 cycles.
  - branch, jump 3 cycles.
  - illegal 2 cycles.
- Each cycle mem_ready is low in FETCH, MEMRD or MEMWR adds one cycle. Outputs hold constant during the stall.
- mem_ready is ignored in every other state.
- Reset (asynchronous, immediate on reset_n low):
  - state=0000, instr_count=0, illegal_op=0.
  - While reset_n is low, all write/read enables are forced to 0. Selects take their FETCH values.
  - First fetch begins on the first rising edge after reset_n rises.
- Reset mid-instruction abandons the instruction with no further writes and no count.

## Structure
- `mips16_pkg` holds:
  - the ten state encodings.
  - opcode constants (OP_LOAD 1000, OP_STORE 1001, OP_BRANCH 1010, OP_JUMP 1011), shared with `AluControl`.
  - OpAlu codes.
  - ALUSrcB/PCSource select codes.
- Sub-module `control_decode`: purely combinational state→controls map. `control_unit` keeps the state register, next-state logic and counter.

## Test plan
- Reset, then Opcode=0010 with mem_ready=1 → states 0000,0001,0110,0111,0000; OpAlu 00,00,10,00; RegWrite=1 only in 0111; instr_count=1.
- Load (1000), mem_ready low for 3 cycles in MEMRD → 0000,0001,0010,0011×4,0100,0000; MemRead and IorD held high through the stall; RegWrite+MemtoReg in 0100.
- Store (1001) → 0000,0001,0010,0101,0000; MemWrite=1 only in 0101; instr_count +1.
- Branch (1010) → 0000,0001,1000,0000 with OpAlu=01, PCWriteCond=1, PCSource=01 in 1000. Jump (1011) → 0000,0001,1001,0000 with PCWrite=1, PCSource=10.
- Opcode=1110 → 0000,0001,0000; illegal_op pulses in 0001; no enables asserted; instr_count unchanged.
- reset_n low mid-MEMWR with mem_ready=0 → MemWrite drops without waiting for a clock edge, state=0000, instr_count=0. Preload instr_count to 0xFFFF, then retire one instruction → 0x0000.
